retire_monitor: RTL and testbench

//  Consumes the writeback-stage retire stream of the pipelined CPU (pc_WB plus a valid qualifier).

---
 rtl/retire_monitor.sv | 161 ++++++++++++++++
 tb/tb_retire_monitor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/retire_monitor.sv
// retire_monitor
//   Watches the writeback-stage retire stream of the pipelined CPU. While running it counts
//   cycles and valid retires, ends the run when HALT_PC retires, and times out when nothing
//   retires for WDOG_CYCLES consecutive cycles.
//
// Optional feature macro: RETIRE_TRACE_EN
//   defined   -> circular buffer of the last TRACE_DEPTH retired PCs, read by index
//   undefined -> no storage, trace_pc_o and trace_cnt_o tied to 0
//
// Ports
//   clk           clock, rising edge
//   rstn          asynchronous active-low reset
//   start_i       begin measurement (IDLE only)
//   clr_i         synchronous return to IDLE, overrides start_i
//   wb_valid_i    WB stage holds a real retiring instruction
//   wb_pc_i       PC of the instruction in WB
//   running_o     in RUN
//   halted_o      halt PC retired (sticky until clr_i)
//   timeout_o     watchdog expired (sticky until clr_i)
//   cycle_cnt_o   cycles spent in RUN (saturating)
//   retire_cnt_o  valid retires seen in RUN (saturating)
//   trace_idx_i   trace read index, 0 = most recent retire
//   trace_pc_o    traced PC at trace_idx_i, 0 when the index holds no entry
//   trace_cnt_o   number of valid trace entries

module retire_monitor #(
    parameter logic [31:0] HALT_PC     = 32'h8000_0078,
    parameter int unsigned WDOG_CYCLES = 1024,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TRACE_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start_i,
    input  logic                           clr_i,
    input  logic                           wb_valid_i,
    input  logic [31:0]                    wb_pc_i,
    output logic                           running_o,
    output logic                           halted_o,
    output logic                           timeout_o,
    output logic [CNT_W-1:0]               cycle_cnt_o,
    output logic [CNT_W-1:0]               retire_cnt_o,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx_i,
    output logic [31:0]                    trace_pc_o,
    output logic [$clog2(TRACE_DEPTH):0]   trace_cnt_o
);

    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES);
    localparam int unsigned IDX_W  = $clog2(TRACE_DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StHalt, StTimeout} state_e;

    state_e             state_q;
    logic               running_q, halted_q, timeout_q;
    logic [CNT_W-1:0]   cycle_cnt_q, retire_cnt_q;
    logic [WDOG_W-1:0]  wdog_q;

    logic retire;
    assign retire = (state_q == StRun) && wb_valid_i;

`ifdef RETIRE_TRACE_EN
    logic [31:0]      trace_mem [TRACE_DEPTH];
    logic [IDX_W-1:0] wptr_q;
    logic [IDX_W:0]   tcnt_q;
    logic [IDX_W-1:0] rd_ptr;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            running_q    <= 1'b0;
            halted_q     <= 1'b0;
            timeout_q    <= 1'b0;
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
            wdog_q       <= '0;
`ifdef RETIRE_TRACE_EN
            wptr_q       <= '0;
            tcnt_q       <= '0;
`endif
        end else if (clr_i) begin
            state_q      <= StIdle;
            running_q    <= 1'b0;
            halted_q     <= 1'b0;
            timeout_q    <= 1'b0;
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
            wdog_q       <= '0;
`ifdef RETIRE_TRACE_EN
            wptr_q       <= '0;
            tcnt_q       <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q      <= StRun;
                        running_q    <= 1'b1;
                        cycle_cnt_q  <= '0;
                        retire_cnt_q <= '0;
                        wdog_q       <= '0;
`ifdef RETIRE_TRACE_EN
                        wptr_q       <= '0;
                        tcnt_q       <= '0;
`endif
                    end
                end
                StRun: begin
                    if (cycle_cnt_q != '1) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
                    if (wb_valid_i) begin
                        if (retire_cnt_q != '1) retire_cnt_q <= retire_cnt_q + CNT_W'(1);
                        wdog_q <= '0;
`ifdef RETIRE_TRACE_EN
                        wptr_q <= wptr_q + IDX_W'(1);
                        if (tcnt_q != (IDX_W+1)'(TRACE_DEPTH)) tcnt_q <= tcnt_q + (IDX_W+1)'(1);
`endif
                        // The halting retire is counted on the same edge it ends the run.
                        if (wb_pc_i == HALT_PC) begin
                            state_q   <= StHalt;
                            running_q <= 1'b0;
                            halted_q  <= 1'b1;
                        end
                    end else begin
                        wdog_q <= wdog_q + WDOG_W'(1);
                        if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
                            state_q   <= StTimeout;
                            running_q <= 1'b0;
                            timeout_q <= 1'b1;
                        end
                    end
                end
                StHalt, StTimeout: ;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign running_o    = running_q;
    assign halted_o     = halted_q;
    assign timeout_o    = timeout_q;
    assign cycle_cnt_o  = cycle_cnt_q;
    assign retire_cnt_o = retire_cnt_q;

`ifdef RETIRE_TRACE_EN
    // Storage needs no reset: tcnt_q gates every read.
    always_ff @(posedge clk) begin
        if (retire && !clr_i) trace_mem[wptr_q] <= wb_pc_i;
    end

    // Most recent entry sits just behind the write pointer; wrap is free at power-of-2 depth.
    assign rd_ptr      = wptr_q - IDX_W'(1) - trace_idx_i;
    assign trace_pc_o  = ({1'b0, trace_idx_i} >= tcnt_q) ? 32'h0 : trace_mem[rd_ptr];
    assign trace_cnt_o = tcnt_q;
`else
    logic unused_trace;
    assign unused_trace = ^{trace_idx_i, retire};
    assign trace_pc_o   = 32'h0;
    assign trace_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_retire_monitor.sv
module tb_retire_monitor;

    localparam logic [31:0] HALT = 32'h8000_0078;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start_i, clr_i, wb_valid_i;
    logic [31:0] wb_pc_i;
    logic        running_o, halted_o, timeout_o;
    logic [31:0] cycle_cnt_o, retire_cnt_o;
    logic [2:0]  trace_idx_i;
    logic [31:0] trace_pc_o;
    logic [3:0]  trace_cnt_o;

    // Narrow-counter instance sharing the same stimulus, for saturation.
    logic        s_running, s_halted, s_timeout;
    logic [2:0]  s_cycle, s_retire;
    logic [31:0] s_unused_pc;
    logic [3:0]  s_unused_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    retire_monitor #(
        .HALT_PC    (HALT),
        .WDOG_CYCLES(4),
        .CNT_W      (32),
        .TRACE_DEPTH(8)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start_i     (start_i),
        .clr_i       (clr_i),
        .wb_valid_i  (wb_valid_i),
        .wb_pc_i     (wb_pc_i),
        .running_o   (running_o),
        .halted_o    (halted_o),
        .timeout_o   (timeout_o),
        .cycle_cnt_o (cycle_cnt_o),
        .retire_cnt_o(retire_cnt_o),
        .trace_idx_i (trace_idx_i),
        .trace_pc_o  (trace_pc_o),
        .trace_cnt_o (trace_cnt_o)
    );

    retire_monitor #(
        .HALT_PC    (HALT),
        .WDOG_CYCLES(16),
        .CNT_W      (3),
        .TRACE_DEPTH(8)
    ) dut_sat (
        .clk         (clk),
        .rstn        (rstn),
        .start_i     (start_i),
        .clr_i       (clr_i),
        .wb_valid_i  (wb_valid_i),
        .wb_pc_i     (wb_pc_i),
        .running_o   (s_running),
        .halted_o    (s_halted),
        .timeout_o   (s_timeout),
        .cycle_cnt_o (s_cycle),
        .retire_cnt_o(s_retire),
        .trace_idx_i (trace_idx_i),
        .trace_pc_o  (s_unused_pc),
        .trace_cnt_o (s_unused_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".running"}, 32'(running_o), 32'd0);
        check({tag, ".halted"},  32'(halted_o),  32'd0);
        check({tag, ".timeout"}, 32'(timeout_o), 32'd0);
        check({tag, ".cycles"},  cycle_cnt_o,    32'd0);
        check({tag, ".retires"}, retire_cnt_o,   32'd0);
        check({tag, ".tcnt"},    32'(trace_cnt_o), 32'd0);
    endtask

    initial begin
        rstn = 1'b0; start_i = 1'b0; clr_i = 1'b0; wb_valid_i = 1'b0;
        wb_pc_i = 32'h0; trace_idx_i = 3'd0;
        #12;
        check_idle("reset");
        rstn = 1'b1;
        step();

        // 1: five retires then the halt PC.
        start_i = 1'b1; step(); start_i = 1'b0;
        check("t1.running", 32'(running_o), 32'd1);
        check("t1.cycles0", cycle_cnt_o, 32'd0);
        wb_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wb_pc_i = 32'h8000_0000 + 32'(4 * k);
            step();
        end
        check("t1.not_halted", 32'(halted_o), 32'd0);
        wb_pc_i = HALT; step();
        wb_valid_i = 1'b0;
        check("t1.halted",  32'(halted_o),  32'd1);
        check("t1.running_off", 32'(running_o), 32'd0);
        check("t1.retires", retire_cnt_o, 32'd6);
        check("t1.cycles",  cycle_cnt_o,  32'd6);
`ifdef RETIRE_TRACE_EN
        check("t1.tcnt", 32'(trace_cnt_o), 32'd6);
        trace_idx_i = 3'd0; #1 check("t1.trace0", trace_pc_o, HALT);
        trace_idx_i = 3'd1; #1 check("t1.trace1", trace_pc_o, 32'h8000_0010);
        trace_idx_i = 3'd5; #1 check("t1.trace5", trace_pc_o, 32'h8000_0000);
        trace_idx_i = 3'd6; #1 check("t1.trace6_empty", trace_pc_o, 32'h0);
        trace_idx_i = 3'd0;
`endif
        wb_valid_i = 1'b1; wb_pc_i = 32'h1234;
        step(); step();
        wb_valid_i = 1'b0;
        check("t1.frozen_ret", retire_cnt_o, 32'd6);
        check("t1.frozen_cyc", cycle_cnt_o,  32'd6);
        check("t1.sticky",     32'(halted_o), 32'd1);

        // 2: bubbles, including a bubble carrying the halt PC.
        clr_i = 1'b1; step(); clr_i = 1'b0;
        check_idle("t2.clr");
        start_i = 1'b1; step(); start_i = 1'b0;
        wb_valid_i = 1'b1; wb_pc_i = 32'h100; step();
        wb_valid_i = 1'b0; wb_pc_i = HALT;    step();
        check("t2.bubble_no_halt", 32'(halted_o), 32'd0);
        check("t2.bubble_running", 32'(running_o), 32'd1);
        wb_pc_i = 32'h0;                      step();
        wb_valid_i = 1'b1; wb_pc_i = 32'h104; step();
        wb_pc_i = HALT;                       step();
        wb_valid_i = 1'b0;
        check("t2.halted",  32'(halted_o), 32'd1);
        check("t2.retires", retire_cnt_o, 32'd3);
        check("t2.cycles",  cycle_cnt_o,  32'd5);

        // 4: clr and start together in HALT go to IDLE; start alone then runs.
        clr_i = 1'b1; start_i = 1'b1; step(); clr_i = 1'b0; start_i = 1'b0;
        check_idle("t4.clr_start");
        start_i = 1'b1; step(); start_i = 1'b0;
        check("t4.running", 32'(running_o), 32'd1);

        // 3: watchdog of 4 with no retires.
        step(); step(); step();
        check("t3.not_yet", 32'(timeout_o), 32'd0);
        step();
        check("t3.timeout", 32'(timeout_o), 32'd1);
        check("t3.running_off", 32'(running_o), 32'd0);
        check("t3.cycles",  cycle_cnt_o,  32'd4);
        check("t3.retires", retire_cnt_o, 32'd0);
        start_i = 1'b1; step(); start_i = 1'b0; step();
        check("t3.start_ignored", 32'(timeout_o), 32'd1);
        check("t3.frozen_cyc", cycle_cnt_o, 32'd4);

        // 5: asynchronous reset mid-run.
        clr_i = 1'b1; step(); clr_i = 1'b0;
        start_i = 1'b1; step(); start_i = 1'b0;
        wb_valid_i = 1'b1; wb_pc_i = 32'h200; step(); step();
        check("t5.pre_retires", retire_cnt_o, 32'd2);
        #3 rstn = 1'b0;
        #1;
        check_idle("t5.async");
        #1 rstn = 1'b1;
        step();
        check("t5.idle_after", 32'(running_o), 32'd0);
        check("t5.no_count",   retire_cnt_o, 32'd0);
        wb_valid_i = 1'b0;

        // 6: ten retires into an eight-entry trace; narrow counters saturate.
        start_i = 1'b1; step(); start_i = 1'b0;
        wb_valid_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wb_pc_i = 32'(4 * k);
            step();
        end
        wb_valid_i = 1'b0;
        check("t6.retires", retire_cnt_o, 32'd10);
        check("sat.retires", 32'(s_retire), 32'd7);
        check("sat.cycles",  32'(s_cycle),  32'd7);
        check("sat.running", 32'(s_running), 32'd1);
        trace_idx_i = 3'd0; #1;
`ifdef RETIRE_TRACE_EN
        check("t6.tcnt",   32'(trace_cnt_o), 32'd8);
        check("t6.trace0", trace_pc_o, 32'h24);
        trace_idx_i = 3'd7; #1;
        check("t6.trace7", trace_pc_o, 32'h08);
`else
        check("t6.tcnt_off",   32'(trace_cnt_o), 32'd0);
        check("t6.trace0_off", trace_pc_o, 32'h0);
        trace_idx_i = 3'd7; #1;
        check("t6.trace7_off", trace_pc_o, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
